pawc_wb_arbiter: RTL

Round-robin Wishbone B4 classic arbiter that shares the single system slave bus between NUM_MASTERS requesters: picorv32_wb, the CSI/DMA engine, and the debug bridge.
- Grant is held for the whole cycle (cyc), so locked read-modify-write sequences work.
- A bus-timeout watchdog terminates transfers to unresponsive slaves.
- Sits in pawc_top between the masters and the address decoder.

---
 rtl/pawc_wb_pkg.sv | 13 +
 rtl/pawc_rr_pick.sv | 27 ++
 rtl/pawc_wb_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pawc_wb_pkg.sv
// Shared defaults and types for the PAWC Wishbone interconnect.
package pawc_wb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_e;

endpackage

// File: rtl/pawc_rr_pick.sv
// Combinational round-robin picker: first requester strictly after rr_ptr, wrapping upward.
module pawc_rr_pick
  import pawc_wb_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = 1; k <= int'(N); k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % int'(N);
      if (!any_req && req[idx]) begin
        winner  = IDX_W'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pawc_wb_arbiter.sv
// Round-robin Wishbone B4 classic arbiter with cycle-long grants and a bus-timeout watchdog.
module pawc_wb_arbiter
  import pawc_wb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF,
  parameter int unsigned SEL_W          = DATA_W / 8
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel_i,
  output logic [DATA_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [ADDR_W-1:0]             s_adr_o,
  output logic [DATA_W-1:0]             s_dat_o,
  output logic [SEL_W-1:0]              s_sel_o,
  input  logic [DATA_W-1:0]             s_dat_i,
  input  logic                          s_ack_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          timeout_o,
  input  logic                          timeout_clr_i
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

  arb_state_e       state;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             grant_valid;
  logic             own_cyc;
  logic             own_stb;
  logic             xfer;
  logic             arb_en;
  logic             wd_fire;

  assign grant_valid = (state == ARB_OWNED);

  pawc_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (m_cyc_i),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (grant_idx == IDX_W'(i)) begin
        own_cyc = m_cyc_i[i];
        own_stb = m_stb_i[i];
        s_we_o  = m_we_i[i];
        s_adr_o = m_adr_i[i*ADDR_W +: ADDR_W];
        s_dat_o = m_dat_i[i*DATA_W +: DATA_W];
        s_sel_o = m_sel_i[i*SEL_W +: SEL_W];
      end
    end
  end

  assign s_cyc_o = grant_valid & own_cyc;
  assign xfer    = s_cyc_o & own_stb;
  assign s_stb_o = xfer & ~wd_fire;
  assign m_dat_o = wd_fire ? TIMEOUT_DATA : s_dat_i;
  // Re-arbitrate only when nobody holds the bus, so locked RMW sequences keep their grant.
  assign arb_en  = ~grant_valid | ~own_cyc;

  always_comb begin
    m_ack_o = '0;
    grant_o = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      grant_o[i] = grant_valid & (grant_idx == IDX_W'(i));
      m_ack_o[i] = grant_o[i] & (s_ack_i | wd_fire);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (arb_en) begin
        if (any_req) begin
          state     <= ARB_OWNED;
          grant_idx <= winner;
          rr_ptr    <= winner;
        end else begin
          state     <= ARB_IDLE;
        end
      end
      if (wd_fire) begin
        timeout_o <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_o <= 1'b0;
      end
    end
  end

  if (TIMEOUT_CYCLES == 0) begin : g_no_wdog
    assign wd_fire = 1'b0;
  end else begin : g_wdog
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;

    // A slave ack in the would-fire cycle wins over the timeout.
    assign wd_fire = xfer & ~s_ack_i & (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Grant changes only happen while xfer is low, which already clears the count.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        wd_cnt <= '0;
      end else if (!xfer || s_ack_i || wd_fire) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule
